// File: rtl/uart_framebuf.sv
// uart_framebuf: byte framebuffer loaded from a UART byte stream and read
// sequentially by the display driver.
//
// Command bytes arriving from the UART:
//   0x00..0x7F  RUN      next byte D is written to (header+1) consecutive addresses
//   0x80        HOME     write index back to 0
//   0x81        CLEAR    zero every location, then write index back to 0
//   0x82        SETADDR  next two bytes LO, HI set the write index
//   0x83        CLR_OVR  clear the sticky overrun flag
//   0x84..0xFF  ignored
//
// The read side is a plain one-cycle registered read that never waits on the
// command FSM, so the display keeps refreshing during long fills and clears.
module uart_framebuf #(
    parameter int COLUMNS = 128,
    parameter int PAGES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_received,
    input  logic [7:0] uart_rx_byte,
    input  logic       d_read,
    input  logic       d_frame_start,
    output logic [7:0] d_data,
    output logic       d_ack,
    output logic       busy,
    output logic       rx_overrun
);

    localparam int DEPTH = COLUMNS * PAGES;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [7:0] CMD_HOME    = 8'h80;
    localparam logic [7:0] CMD_CLEAR   = 8'h81;
    localparam logic [7:0] CMD_SETADDR = 8'h82;
    localparam logic [7:0] CMD_CLR_OVR = 8'h83;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_WAIT_LO,
        S_WAIT_HI,
        S_FILL,
        S_CLEAR
    } state_t;

    // Command FSM state.
    state_t        state_q,   state_d;
    logic [AW-1:0] wr_idx_q,  wr_idx_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    // Remaining writes of the current run; a run is 1..128 bytes long.
    logic [7:0]    cnt_q,     cnt_d;
    logic [7:0]    data_q,    data_d;
    logic [7:0]    lo_q,      lo_d;
    logic          busy_q,    busy_d;
    logic          ovr_q,     ovr_d;

    // Read side.
    logic [AW-1:0] rd_idx_q,  rd_idx_d;
    logic [7:0]    d_data_q;
    logic          d_ack_q;

    // Single write port and single read port of the frame memory.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;

    logic [7:0]    mem [DEPTH];

    // Command decode, run/clear sequencing and write-port control.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        clr_idx_d = clr_idx_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        lo_d      = lo_q;
        ovr_d     = ovr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_idx_q;
        mem_wdata = data_q;

        case (state_q)
            S_IDLE: begin
                if (uart_received) begin
                    if (!uart_rx_byte[7]) begin
                        // Header encodes length-1, so 0x7F means 128 bytes.
                        cnt_d   = {1'b0, uart_rx_byte[6:0]} + 8'd1;
                        state_d = S_WAIT_DATA;
                    end else begin
                        case (uart_rx_byte)
                            CMD_HOME: wr_idx_d = '0;
                            CMD_CLEAR: begin
                                clr_idx_d = '0;
                                state_d   = S_CLEAR;
                            end
                            CMD_SETADDR: state_d = S_WAIT_LO;
                            CMD_CLR_OVR: ovr_d = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end

            S_WAIT_DATA: begin
                if (uart_received) begin
                    data_d  = uart_rx_byte;
                    state_d = S_FILL;
                end
            end

            S_WAIT_LO: begin
                if (uart_received) begin
                    lo_d    = uart_rx_byte;
                    state_d = S_WAIT_HI;
                end
            end

            S_WAIT_HI: begin
                if (uart_received) begin
                    // Only the low AW bits of {HI,LO} address the buffer.
                    wr_idx_d = AW'({uart_rx_byte, lo_q});
                    state_d  = S_IDLE;
                end
            end

            S_FILL: begin
                mem_we    = 1'b1;
                mem_waddr = wr_idx_q;
                mem_wdata = data_q;
                wr_idx_d  = wr_idx_q + IDX_ONE;
                cnt_d     = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_IDLE;
                end
                // The FSM cannot accept a byte here; flag the loss.
                if (uart_received) begin
                    ovr_d = 1'b1;
                end
            end

            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = 8'h00;
                clr_idx_d = clr_idx_q + IDX_ONE;
                if (clr_idx_q == LAST_IDX) begin
                    state_d  = S_IDLE;
                    wr_idx_d = '0;
                end
                if (uart_received) begin
                    ovr_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Registered so busy lines up exactly with the FILL/CLEAR cycles.
        busy_d = (state_d == S_FILL) || (state_d == S_CLEAR);
    end

    // Command FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_idx_q  <= '0;
            clr_idx_q <= '0;
            cnt_q     <= 8'd0;
            data_q    <= 8'd0;
            lo_q      <= 8'd0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            clr_idx_q <= clr_idx_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

    // Read index: frame start wins and, with a simultaneous read, consumes address 0.
    always_comb begin
        rd_idx_d  = rd_idx_q;
        mem_raddr = rd_idx_q;
        if (d_frame_start) begin
            mem_raddr = '0;
            rd_idx_d  = d_read ? IDX_ONE : '0;
        end else if (d_read) begin
            rd_idx_d = rd_idx_q + IDX_ONE;
        end
    end

    // Read index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
        end
    end

    // Memory write port; contents survive reset, but a write is suppressed in the reset cycle
    // so that a fill or clear aborts immediately.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port; nonblocking semantics give read-first on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_data_q <= 8'd0;
        end else if (d_read) begin
            d_data_q <= mem[mem_raddr];
        end
    end

    // Acknowledge strobe, one cycle after each request.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_ack_q <= 1'b0;
        end else begin
            d_ack_q <= d_read;
        end
    end

    assign d_data     = d_data_q;
    assign d_ack      = d_ack_q;
    assign busy       = busy_q;
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_framebuf.sv
// Directed bench for uart_framebuf (default 128x8 geometry, 1024 bytes).
module tb_uart_framebuf;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_received;
    logic [7:0] uart_rx_byte;
    logic       d_read;
    logic       d_frame_start;
    logic [7:0] d_data;
    logic       d_ack;
    logic       busy;
    logic       rx_overrun;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_framebuf dut (
        .clk           (clk),
        .rst           (rst),
        .uart_received (uart_received),
        .uart_rx_byte  (uart_rx_byte),
        .d_read        (d_read),
        .d_frame_start (d_frame_start),
        .d_data        (d_data),
        .d_ack         (d_ack),
        .busy          (busy),
        .rx_overrun    (rx_overrun)
    );

    // Present one byte for one clock; returns just after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        uart_received = 1'b1;
        uart_rx_byte  = b;
        @(posedge clk);
        #1;
        uart_received = 1'b0;
    endtask

    // Wait (bounded) for busy to fall; reports whether the bound expired.
    task automatic wait_idle(output logic expired);
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        expired = busy;
    endtask

    // Restart the frame and read sequentially until address addr is returned.
    task automatic read_at(input int addr, output logic [7:0] data, output logic ack);
        d_frame_start = 1'b1;
        d_read        = 1'b1;
        @(posedge clk);
        #1;
        d_frame_start = 1'b0;
        for (int i = 0; i < addr; i++) begin
            @(posedge clk);
            #1;
        end
        d_read = 1'b0;
        data   = d_data;
        ack    = d_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({d_data, d_ack, busy, rx_overrun} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h ack=%b busy=%b ovr=%b, want 00 0 0 0",
                     d_data, d_ack, busy, rx_overrun);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_run_basic();
        logic [7:0] rd;
        logic       ack;
        logic       exp_busy;
        logic       to;
        logic [7:0] exp_rd [4] = '{8'hAA, 8'hAA, 8'hAA, 8'hBB};
        send_byte(8'h02);
        send_byte(8'hAA);
        // busy high for exactly three cycles
        for (int i = 0; i < 4; i++) begin
            exp_busy = (i < 3);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL run_busy_cyc%0d: got %b, want %b", i, busy, exp_busy);
            end
            @(posedge clk);
            #1;
        end
        // next run lands at wr_idx=3
        send_byte(8'h00);
        send_byte(8'hBB);
        wait_idle(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL run_idle_timeout: busy=%b, want 0", busy);
        end
        for (int a = 0; a < 4; a++) begin
            read_at(a, rd, ack);
            vectors++;
            if (rd !== exp_rd[a] || ack !== 1'b1) begin
                miscompares++;
                $display("FAIL run_rd%0d: got %h ack=%b, want %h ack=1", a, rd, ack, exp_rd[a]);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (d_ack !== 1'b0 || d_data !== 8'hBB) begin
            miscompares++;
            $display("FAIL ack_idle: got ack=%b data=%h, want ack=0 data=bb", d_ack, d_data);
        end
    endtask

    task automatic test_setaddr_wrap();
        logic [7:0] rd;
        logic       ack;
        logic       to;
        send_byte(8'h82);
        send_byte(8'hFF);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h55);
        wait_idle(to);
        send_byte(8'h00);
        send_byte(8'h66);
        wait_idle(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL wrap_idle_timeout: busy=%b, want 0", busy);
        end
        read_at(0, rd, ack);
        vectors++;
        if (rd !== 8'h55) begin
            miscompares++;
            $display("FAIL wrap_mem000: got %h, want 55", rd);
        end
        read_at(1, rd, ack);
        vectors++;
        if (rd !== 8'h66) begin
            miscompares++;
            $display("FAIL wrap_mem001: got %h, want 66", rd);
        end
        read_at(2, rd, ack);
        vectors++;
        if (rd !== 8'hAA) begin
            miscompares++;
            $display("FAIL wrap_mem002: got %h, want aa", rd);
        end
        read_at(1023, rd, ack);
        vectors++;
        if (rd !== 8'h55) begin
            miscompares++;
            $display("FAIL wrap_mem3ff: got %h, want 55", rd);
        end
    endtask

    task automatic test_clear();
        logic [7:0] rd;
        logic       ack;
        logic       to;
        int         n   = 0;
        int         bad = 0;
        send_byte(8'h81);
        while (busy && n < 2000) begin
            n++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (n != 1024) begin
            miscompares++;
            $display("FAIL clear_busy_cycles: got %0d, want 1024", n);
        end
        d_frame_start = 1'b1;
        d_read        = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #1;
            d_frame_start = 1'b0;
            if (d_data !== 8'h00) bad++;
        end
        d_read = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL clear_all_zero: got %0d nonzero bytes, want 0", bad);
        end
        send_byte(8'h00);
        send_byte(8'h11);
        wait_idle(to);
        read_at(0, rd, ack);
        vectors++;
        if (rd !== 8'h11) begin
            miscompares++;
            $display("FAIL clear_home_mem0: got %h, want 11", rd);
        end
        read_at(1, rd, ack);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("FAIL clear_mem1: got %h, want 00", rd);
        end
    endtask

    task automatic test_overrun();
        logic       to;
        logic [7:0] exp;
        int         bad = 0;
        send_byte(8'h7F);
        send_byte(8'h33);
        send_byte(8'h05);
        vectors++;
        if (rx_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set: got %b, want 1", rx_overrun);
        end
        // a read during FILL is still served
        d_read = 1'b1;
        @(posedge clk);
        #1;
        d_read = 1'b0;
        vectors++;
        if (d_ack !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_in_fill: got ack=%b busy=%b, want 1 1", d_ack, busy);
        end
        wait_idle(to);
        vectors++;
        if (to || rx_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_sticky: got busy=%b ovr=%b, want 0 1", busy, rx_overrun);
        end
        send_byte(8'h00);
        send_byte(8'h77);
        wait_idle(to);
        d_frame_start = 1'b1;
        d_read        = 1'b1;
        for (int i = 0; i < 131; i++) begin
            @(posedge clk);
            #1;
            d_frame_start = 1'b0;
            exp = (i == 0) ? 8'h11 : (i <= 128) ? 8'h33 : (i == 129) ? 8'h77 : 8'h00;
            if (d_data !== exp) bad++;
        end
        d_read = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL ovr_fill_contents: got %0d wrong bytes in 0..130, want 0", bad);
        end
        send_byte(8'h83);
        vectors++;
        if (rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear: got %b, want 0", rx_overrun);
        end
    endtask

    task automatic test_read_wrap_frame();
        logic [7:0] got0, got1, got1023, got1024;
        d_frame_start = 1'b1;
        d_read        = 1'b1;
        for (int i = 0; i < 1025; i++) begin
            @(posedge clk);
            #1;
            d_frame_start = 1'b0;
            if (i == 0)    got0    = d_data;
            if (i == 1)    got1    = d_data;
            if (i == 1023) got1023 = d_data;
            if (i == 1024) got1024 = d_data;
        end
        vectors++;
        if (got0 !== 8'h11 || got1 !== 8'h33 || got1023 !== 8'h00) begin
            miscompares++;
            $display("FAIL rd_frame: got %h %h %h, want 11 33 00", got0, got1, got1023);
        end
        vectors++;
        if (got1024 !== 8'h11) begin
            miscompares++;
            $display("FAIL rd_wrap_1025: got %h, want 11", got1024);
        end
        // restart from address 0 mid-frame
        d_frame_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            d_frame_start = 1'b0;
        end
        d_frame_start = 1'b1;
        @(posedge clk);
        #1;
        d_frame_start = 1'b0;
        vectors++;
        if (d_data !== 8'h11) begin
            miscompares++;
            $display("FAIL fs_midframe_rd0: got %h, want 11", d_data);
        end
        @(posedge clk);
        #1;
        d_read = 1'b0;
        vectors++;
        if (d_data !== 8'h33) begin
            miscompares++;
            $display("FAIL fs_midframe_rd1: got %h, want 33", d_data);
        end
    endtask

    task automatic test_rst_mid_fill();
        logic [7:0] rd;
        logic       ack;
        logic       to;
        send_byte(8'h82);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h7F);
        send_byte(8'h33);
        repeat (64) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_fill_busy: got %b, want 0", busy);
        end
        send_byte(8'h00);
        send_byte(8'h44);
        wait_idle(to);
        read_at(0, rd, ack);
        vectors++;
        if (rd !== 8'h44) begin
            miscompares++;
            $display("FAIL rst_fill_wridx0: got %h, want 44", rd);
        end
        read_at(512, rd, ack);
        vectors++;
        if (rd !== 8'h33) begin
            miscompares++;
            $display("FAIL rst_fill_mem200: got %h, want 33", rd);
        end
        read_at(575, rd, ack);
        vectors++;
        if (rd !== 8'h33) begin
            miscompares++;
            $display("FAIL rst_fill_mem23f: got %h, want 33", rd);
        end
        read_at(608, rd, ack);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_fill_mem260: got %h, want 00", rd);
        end
    endtask

    initial begin
        rst           = 1'b1;
        uart_received = 1'b0;
        uart_rx_byte  = 8'h00;
        d_read        = 1'b0;
        d_frame_start = 1'b0;
        test_reset();
        test_run_basic();
        test_setaddr_wrap();
        test_clear();
        test_overrun();
        test_read_wrap_frame();
        test_rst_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
